// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one ALU operation at a time through an external
// datapath. It has three registers, A/B/C.
//   LOAD  : drives the operands and strobes the A and B write enables.
//   EXEC  : waits EXEC_WAIT cycles and strobes C in the last one. The flags
//           are captured at the same edge.
//   READ  : captures C into rsp_result.
//   RESP  : presents rsp_result/rsp_flags until the consumer accepts them.
// All outputs are registered. Each one is written on the edge that moves the
// FSM into the state whose value it shows.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; req_op/req_a/req_b are the payload
//   operando1/operando2   operand data to datapath registers A/B
//   alu_op                ALU selector to the datapath (zero when not in use)
//   reg_load_a/b/c        datapath register write enables (single-cycle pulses)
//   dp_result, dp_flags   datapath register C contents / combinational flags
//   rsp_valid/rsp_ready   response handshake; rsp_result/rsp_flags the payload
//   busy                  high whenever the FSM is not idle
//   op_count              completed responses, wraps at 256
module alu_sequencer #(
  parameter int EXEC_WAIT = 1  // EXEC cycles before C is written, 1..15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic [7:0] operando1,
  output logic [7:0] operando2,
  output logic [7:0] alu_op,
  output logic       reg_load_a,
  output logic       reg_load_b,
  output logic       reg_load_c,
  input  logic [7:0] dp_result,
  input  logic [7:0] dp_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [7:0] rsp_flags,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, READ, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_WAIT - 1);

  state_t     state;
  logic [3:0] cnt;

  // operando1/2 and alu_op double as the request latches. They are loaded on
  // the accept edge. The operands hold until the next accept. alu_op is
  // cleared when the response is presented.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      operando1  <= 8'd0;
      operando2  <= 8'd0;
      alu_op     <= 8'd0;
      reg_load_a <= 1'b0;
      reg_load_b <= 1'b0;
      reg_load_c <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'd0;
      rsp_flags  <= 8'd0;
      op_count   <= 8'd0;
      busy       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      // Load strobes are single-cycle pulses, so they default low each edge.
      reg_load_a <= 1'b0;
      reg_load_b <= 1'b0;
      reg_load_c <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            operando1  <= req_a;
            operando2  <= req_b;
            alu_op     <= req_op;
            reg_load_a <= 1'b1;
            reg_load_b <= 1'b1;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          cnt        <= CNT_INIT;
          // If there is only one EXEC cycle, it is also the last one.
          reg_load_c <= (CNT_INIT == 4'd0);
          state      <= EXEC;
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            // C is written on this same edge, so flags come from the live ALU.
            rsp_flags <= dp_flags;
            state     <= READ;
          end else begin
            cnt        <= cnt - 4'd1;
            reg_load_c <= (cnt == 4'd1);
          end
        end
        READ: begin
          rsp_result <= dp_result;
          rsp_valid  <= 1'b1;
          alu_op     <= 8'd0;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          alu_op    <= 8'd0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter EXEC_WAIT, default 1, number of EXEC cycles before result write; legal range 1..15.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (sampled on clock rising edge; 0 = reset).
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 req_op  input  8  ALU selector code for the request.
REQ-007 req_a / req_b  input  8 each  first / second operand.
REQ-008 operando1 / operando2  output  8 each  operand data driven to datapath register A / B write ports.
REQ-009 alu_op  output  8  ALU selector driven to datapath.
REQ-010 reg_load_a / reg_load_b / reg_load_c  output  1 each  datapath register A / B / C write enables.
REQ-011 dp_result  input  8  datapath result (register C contents).
REQ-012 dp_flags  input  8  datapath ALU flags (combinational from A/B/alu_op).
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_result / rsp_flags  output  8 each  captured result / flags.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 op_count  output  8  count of completed responses.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, EXEC, READ, RESP; all outputs registered (Moore).
REQ-019 IDLE: req_ready=1; on req_valid=1 at an edge, latch req_op/req_a/req_b and go to LOAD.
REQ-020 req_ready SHALL be 0 in every state except IDLE; req_valid outside IDLE ignored, no request queued.
REQ-021 LOAD (1 cycle): operando1=latched a, operando2=latched b, reg_load_a=1, reg_load_b=1; next EXEC.
REQ-022 EXEC: 4-bit counter loaded with EXEC_WAIT-1 on entry, decrements each cycle; reg_load_c=1 only in final EXEC cycle (counter=0); dp_flags captured into rsp_flags at that edge; next READ.
REQ-023 READ (1 cycle): dp_result captured into rsp_result at end of cycle; next RESP.
REQ-024 alu_op SHALL equal latched op in LOAD, EXEC, READ and be 8'h00 in IDLE and RESP.
REQ-025 operando1/2 SHALL hold latched values from LOAD until return to IDLE; no mid-operation change.
REQ-026 reg_load_a/b/c SHALL never be high outside the single cycles defined above.
REQ-027 RESP: rsp_valid=1; rsp_result/rsp_flags stable while rsp_ready=0, held indefinitely.
REQ-028 rsp_valid=1 and rsp_ready=1 at an edge: op_count increments (wraps 255->0), state -> IDLE, rsp_valid=0 next cycle.
REQ-029 Latency: request accept edge to first rsp_valid=1 cycle = 3+EXEC_WAIT cycles.
REQ-030 Minimum request spacing SHALL be 4+EXEC_WAIT cycles (rsp_ready held high); no overlap of operations.
REQ-031 rsp_result/rsp_flags SHALL retain last values after return to IDLE until next capture.

Reset
REQ-032 reset=0 at an edge: state IDLE, counter 0, all latches, operando1/2, alu_op, rsp_result, rsp_flags, op_count = 0; reg_load_a/b/c, rsp_valid, busy = 0; req_ready=1 from first cycle after reset released.
REQ-033 Reset mid-operation (any state) SHALL abort the transaction: no further load strobes, no response, op_count not incremented.
REQ-034 reset overrides all other inputs in the same cycle, including req_valid and rsp_ready.

Verification
REQ-035 EXEC_WAIT=1, req_op=ADD code, a=8'h12, b=8'h34, rsp_ready=1 -> load_a/b one cycle, load_c one cycle, rsp_valid 4 cycles after accept, rsp_result=8'h46, op_count=1.
REQ-036 EXEC_WAIT=3, same request -> reg_load_c in third EXEC cycle only, rsp_valid 6 cycles after accept.
REQ-037 rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_result stable, req_ready=0, second req_valid ignored; release -> IDLE next cycle.
REQ-038 Reset asserted in EXEC -> next cycle all outputs at reset values, no reg_load_c, no rsp_valid, op_count unchanged.
REQ-039 256 back-to-back completed operations -> op_count wraps to 8'h00; spacing exactly 4+EXEC_WAIT cycles.
REQ-040 Operation setting carry/zero (a=8'hFF, b=8'h01, ADD) -> rsp_result=8'h00, rsp_flags equal dp_flags sampled at reg_load_c edge.
